// File: rtl/tdm_pkg.sv
// Shared types and frame geometry for the TDM demux and its slot counter.
// Defining TDM_PARITY_EN adds a ninth (even-parity) slot to every frame.
package tdm_pkg;

    typedef enum logic [0:0] {
        StHunt,
        StRun
    } tdm_state_e;

`ifdef TDM_PARITY_EN
    localparam int unsigned NUM_SLOTS = 9;
    localparam int unsigned SLOT_W    = 4;
`else
    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned SLOT_W    = 3;
`endif

    // Bits held before commit; the final data bit is taken straight from the wire.
    localparam int unsigned SHADOW_W = NUM_SLOTS - 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position counter for a TDM frame: load-to-1 on sync, clear, wrap after
// the last slot, and hold whenever the current cycle carries no valid bit.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] slot_o
);

    logic [SLOT_W-1:0] slot_d, slot_q;

    always_comb begin
        slot_d = slot_q;
        if (valid_i) begin
            if (clear_i) begin
                slot_d = '0;
            end else if (load_i) begin
                slot_d = SLOT_W'(1);
            end else if (inc_i) begin
                slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux_1x8.sv
// Receive side of the 8:1 TDM link: locks on frame_sync and commits eight lanes per frame.
// Optional TDM_PARITY_EN adds a parity slot and the parity_err output.
module tdm_demux_1x8
    import tdm_pkg::*;
#(
    parameter logic [7:0]  OUT_RESET  = 8'h00,
    parameter int unsigned MAX_MISSES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    input  logic              in_valid,
    input  logic              frame_sync,
    output logic              out0,
    output logic              out1,
    output logic              out2,
    output logic              out3,
    output logic              out4,
    output logic              out5,
    output logic              out6,
    output logic              out7,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
`ifdef TDM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam logic [2:0] MaxMiss = 3'(MAX_MISSES);

    tdm_state_e          state_d, state_q;
    logic [SHADOW_W-1:0] shadow_d, shadow_q;
    logic [2:0]          miss_d, miss_q;
    logic [2:0]          miss_inc;
    logic [7:0]          out_d, out_q;
    logic                frame_valid_d, frame_valid_q;
    logic                sync_err_d, sync_err_q;
    logic                parity_err_d, parity_err_q;
    logic [SLOT_W-1:0]   slot_q;
    logic                cnt_load, cnt_clear, cnt_inc;

    tdm_slot_counter u_slot_counter (
        .clk_i   (clk),
        .rst_i   (reset),
        .valid_i (in_valid),
        .load_i  (cnt_load),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .slot_o  (slot_q)
    );

    assign miss_inc = miss_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        miss_d        = miss_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        parity_err_d  = 1'b0;
        cnt_load      = 1'b0;
        cnt_clear     = 1'b0;
        cnt_inc       = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (frame_sync) begin
                        shadow_d[0] = in;
                        cnt_load    = 1'b1;
                        miss_d      = '0;
                        state_d     = StRun;
                    end
                end
                StRun: begin
                    if (slot_q == '0 && !frame_sync) begin
                        // Missing marker: flywheel on the expected position until too many misses.
                        sync_err_d = 1'b1;
                        if (miss_inc >= MaxMiss) begin
                            state_d   = StHunt;
                            cnt_clear = 1'b1;
                            miss_d    = '0;
                        end else begin
                            miss_d      = miss_inc;
                            shadow_d[0] = in;
                            cnt_load    = 1'b1;
                        end
                    end else if (frame_sync) begin
                        // Marker at slot 0 is normal; anywhere else drops the partial frame.
                        sync_err_d  = (slot_q != '0);
                        shadow_d[0] = in;
                        cnt_load    = 1'b1;
                        miss_d      = '0;
                    end else if (slot_q == LAST_SLOT) begin
                        cnt_inc = 1'b1;
`ifdef TDM_PARITY_EN
                        if ((^shadow_q) == in) begin
                            out_d         = shadow_q;
                            frame_valid_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
`else
                        out_d         = {in, shadow_q};
                        frame_valid_d = 1'b1;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                        for (int unsigned k = 1; k < SHADOW_W; k++) begin
                            if (slot_q == SLOT_W'(k)) begin
                                shadow_d[k] = in;
                            end
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StHunt;
            shadow_q      <= '0;
            miss_q        <= '0;
            out_q         <= OUT_RESET;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            miss_q        <= miss_d;
            out_q         <= out_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            parity_err_q  <= parity_err_d;
        end
    end

    assign {out7, out6, out5, out4, out3, out2, out1, out0} = out_q;

    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == StRun);
    assign sync_err    = sync_err_q;

`ifdef TDM_PARITY_EN
    assign parity_err = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for tdm_demux_1x8 (8-slot build): vector table plus
// hand-written lost-sync, reset-mid-frame and mux-loopback sequences.
module tb_tdm_demux_1x8;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       in_valid;
    logic       frame_sync;
    logic       out0, out1, out2, out3, out4, out5, out6, out7;
    logic       frame_valid;
    logic [2:0] slot;
    logic       locked;
    logic       sync_err;
`ifdef TDM_PARITY_EN
    logic       parity_err;
`endif

    tdm_demux_1x8 dut (
        .clk         (clk),
        .reset       (reset),
        .in          (din),
        .in_valid    (in_valid),
        .frame_sync  (frame_sync),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .out4        (out4),
        .out5        (out5),
        .out6        (out6),
        .out7        (out7),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef TDM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] out_bus;
    assign out_bus = {out7, out6, out5, out4, out3, out2, out1, out0};

    typedef struct {
        bit       v;
        bit       fs;
        bit       d;
        bit [7:0] out;
        bit       fv;
        bit       lk;
        bit       err;
        bit [2:0] slot;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of input and return #1 after the sampling edge.
    task automatic step(input bit v, input bit fs, input bit d);
        in_valid   = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit v, input bit fs, input bit d, input bit [7:0] o,
                       input bit fv, input bit lk, input bit err, input bit [2:0] s);
        vec_t e;
        e.v = v; e.fs = fs; e.d = d; e.out = o; e.fv = fv; e.lk = lk; e.err = err; e.slot = s;
        vecs.push_back(e);
    endtask

    logic [7:0] lanes;

    initial begin
        // Basic frame: slots 0..7 = 1,0,0,1,1,0,1,1 -> out7..out0 = 8'hD9
        add(1, 1, 1, 8'h00, 0, 1, 0, 3'd1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 3'd2);
        add(1, 0, 0, 8'h00, 0, 1, 0, 3'd3);
        add(1, 0, 1, 8'h00, 0, 1, 0, 3'd4);
        add(1, 0, 1, 8'h00, 0, 1, 0, 3'd5);
        add(1, 0, 0, 8'h00, 0, 1, 0, 3'd6);
        add(1, 0, 1, 8'h00, 0, 1, 0, 3'd7);
        add(1, 0, 1, 8'hD9, 1, 1, 0, 3'd0);
        add(0, 0, 0, 8'hD9, 0, 1, 0, 3'd0);
        // Gapped frame: slots 0..7 = 0,1,1,0,0,1,0,0 -> 8'h26; junk on idle cycles
        add(1, 1, 0, 8'hD9, 0, 1, 0, 3'd1);
        add(0, 1, 1, 8'hD9, 0, 1, 0, 3'd1);
        add(1, 0, 1, 8'hD9, 0, 1, 0, 3'd2);
        add(0, 0, 0, 8'hD9, 0, 1, 0, 3'd2);
        add(1, 0, 1, 8'hD9, 0, 1, 0, 3'd3);
        add(0, 1, 0, 8'hD9, 0, 1, 0, 3'd3);
        add(1, 0, 0, 8'hD9, 0, 1, 0, 3'd4);
        add(0, 0, 1, 8'hD9, 0, 1, 0, 3'd4);
        add(1, 0, 0, 8'hD9, 0, 1, 0, 3'd5);
        add(0, 0, 0, 8'hD9, 0, 1, 0, 3'd5);
        add(1, 0, 1, 8'hD9, 0, 1, 0, 3'd6);
        add(0, 0, 0, 8'hD9, 0, 1, 0, 3'd6);
        add(1, 0, 0, 8'hD9, 0, 1, 0, 3'd7);
        add(0, 0, 1, 8'hD9, 0, 1, 0, 3'd7);
        add(1, 0, 0, 8'h26, 1, 1, 0, 3'd0);
        add(0, 0, 0, 8'h26, 0, 1, 0, 3'd0);
        // Early sync at slot 4, then new frame 0,1,1,1,1,1,1,1 -> 8'hFE
        add(1, 1, 1, 8'h26, 0, 1, 0, 3'd1);
        add(1, 0, 0, 8'h26, 0, 1, 0, 3'd2);
        add(1, 0, 1, 8'h26, 0, 1, 0, 3'd3);
        add(1, 0, 1, 8'h26, 0, 1, 0, 3'd4);
        add(1, 1, 0, 8'h26, 0, 1, 1, 3'd1);
        add(1, 0, 1, 8'h26, 0, 1, 0, 3'd2);
        add(1, 0, 1, 8'h26, 0, 1, 0, 3'd3);
        add(1, 0, 1, 8'h26, 0, 1, 0, 3'd4);
        add(1, 0, 1, 8'h26, 0, 1, 0, 3'd5);
        add(1, 0, 1, 8'h26, 0, 1, 0, 3'd6);
        add(1, 0, 1, 8'h26, 0, 1, 0, 3'd7);
        add(1, 0, 1, 8'hFE, 1, 1, 0, 3'd0);
        add(0, 0, 0, 8'hFE, 0, 1, 0, 3'd0);

        reset = 1'b1; din = 1'b0; in_valid = 1'b0; frame_sync = 1'b0;
        @(posedge clk); #1;
        check("reset_out", 32'(out_bus), 32'h00);
        check("reset_slot", 32'(slot), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_fv", 32'(frame_valid), 32'd0);
        check("reset_err", 32'(sync_err), 32'd0);
        reset = 1'b0;
        step(0, 0, 0);
        step(1, 0, 1);  // no sync in HUNT: discarded
        check("hunt_discard_slot", 32'(slot), 32'd0);
        check("hunt_discard_lock", 32'(locked), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].fs, vecs[i].d);
            check($sformatf("vec%0d_out", i), 32'(out_bus), 32'(vecs[i].out));
            check($sformatf("vec%0d_fv", i), 32'(frame_valid), 32'(vecs[i].fv));
            check($sformatf("vec%0d_lock", i), 32'(locked), 32'(vecs[i].lk));
            check($sformatf("vec%0d_err", i), 32'(sync_err), 32'(vecs[i].err));
            check($sformatf("vec%0d_slot", i), 32'(slot), 32'(vecs[i].slot));
        end

        // Lost sync: first missed marker flywheels, second drops to HUNT.
        step(1, 0, 0);
        check("miss1_err", 32'(sync_err), 32'd1);
        check("miss1_lock", 32'(locked), 32'd1);
        check("miss1_slot", 32'(slot), 32'd1);
        for (int i = 0; i < 7; i++) step(1, 0, 1);
        check("miss1_frame_out", 32'(out_bus), 32'hFE);
        step(1, 0, 0);
        check("miss2_err", 32'(sync_err), 32'd1);
        check("miss2_lock", 32'(locked), 32'd0);
        check("miss2_slot", 32'(slot), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0);
            check("hunt_lock", 32'(locked), 32'd0);
            check("hunt_slot", 32'(slot), 32'd0);
            check("hunt_err", 32'(sync_err), 32'd0);
        end
        check("hunt_out_hold", 32'(out_bus), 32'hFE);
        lanes = 8'hD9;
        for (int s = 0; s < 8; s++) step(1, s == 0, lanes[s]);
        check("relock_out", 32'(out_bus), 32'hD9);
        check("relock_fv", 32'(frame_valid), 32'd1);
        check("relock_lock", 32'(locked), 32'd1);

        // Reset in the middle of a frame (asynchronous, between edges).
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check("pre_reset_slot", 32'(slot), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out", 32'(out_bus), 32'h00);
        check("async_reset_slot", 32'(slot), 32'd0);
        check("async_reset_lock", 32'(locked), 32'd0);
        check("async_reset_fv", 32'(frame_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 0, 1);
        check("post_reset_fv", 32'(frame_valid), 32'd0);
        check("post_reset_out", 32'(out_bus), 32'h00);

        // Loopback from an 8:1 mux with counting select, back-to-back frames.
        lanes = 8'b1101_1001;
        for (int f = 0; f < 3; f++) begin
            for (int sel = 0; sel < 8; sel++) begin
                step(1, sel == 0, lanes[sel]);
                if (sel == 0 && f > 0) check("loop_fv_low", 32'(frame_valid), 32'd0);
            end
            check($sformatf("loop%0d_out", f), 32'(out_bus), 32'(lanes));
            check($sformatf("loop%0d_fv", f), 32'(frame_valid), 32'd1);
            check($sformatf("loop%0d_err", f), 32'(sync_err), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Receive end of the 8:1 mux TDM link: the 8x1 mux with a counting select serializes in0..in7 onto one wire, and this block restores the eight lanes.
- Samples a serial bit stream, one bit per valid cycle, tracks slot position from a frame-sync marker and distributes bits to eight registered outputs.
- Outputs update atomically once per complete frame, so lane k always reproduces the mux's input k.
- Sits directly downstream of the mux in the multiplexer library's link demo.

Parameters:
- OUT_RESET, 8'h00, reset/idle value of out7..out0 (bit k drives outk).
- MAX_MISSES, 2, consecutive slot-0 bits without frame_sync tolerated before dropping to HUNT (range 1..7).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  1  serial TDM data bit.
- in_valid  input  1  in/frame_sync are sampled only when high.
- frame_sync  input  1  marks the current bit as slot 0.
- out0..out7  output  1 each  registered lane outputs; outk = slot k of last complete frame.
- frame_valid  output  1  one-cycle pulse, new frame on out0..out7.
- slot  output  3  next slot index expected.
- locked  output  1  high in RUN state.
- sync_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async, immediate): state=HUNT, slot=0, shadow=0, miss count=0, outk=OUT_RESET[k], frame_valid=0, sync_err=0, locked=0.
- in_valid=0: no state, slot, shadow or output change. Pulses deassert next cycle.
- HUNT:
  - in_valid & frame_sync: shadow[0]<=in, slot<=1, go to RUN.
  - Any other valid bit: discarded.
- RUN, valid bit at slot 1..6:
  - No frame_sync: shadow[slot]<=in, slot++.
  - With frame_sync (early sync): sync_err pulse, partial frame discarded, bit taken as slot 0 (shadow[0]<=in, slot<=1). Outputs unchanged.
- RUN, valid bit at slot 7:
  - frame_sync low: on that same edge outk<=shadow[k] for k<7 and out7<=in; frame_valid pulses high that cycle; slot<=0.
  - frame_sync high: treated as early sync (above).
- RUN, valid bit at slot 0:
  - With frame_sync: shadow[0]<=in, slot<=1, miss count<=0.
  - Without frame_sync: sync_err pulse, miss count++, bit still taken as slot 0 (flywheel).
  - When miss count reaches MAX_MISSES: go to HUNT, slot<=0, bit discarded.
- Latency: out/frame_valid become visible one clock after the edge that samples the slot-7 bit.
- Minimum frame period: 8 valid cycles. Back-to-back frames are supported with no idle cycle.
- Reset mid-frame: partial shadow is lost and outputs return to OUT_RESET.

Optional Feature:
- TDM_PARITY_EN defined:
  - Frame is 9 slots; slot 8 carries even parity over slots 0..7. slot widens to 4 bits.
  - Outputs commit at slot 8 only when parity matches.
  - Adds output parity_err (1-bit pulse on mismatch). On mismatch, outputs hold their previous value and frame_valid stays low.
- TDM_PARITY_EN undefined: 8-slot behaviour above; no parity_err port.

Decomposition:
- Package tdm_pkg: state enum (HUNT, RUN), NUM_SLOTS (8, or 9 with parity), SLOT_W.
- Sub-module tdm_slot_counter: slot counter with load-to-1 on sync, wrap, and hold on !in_valid. Reused later by the matching TDM transmitter.

Test Plan:
- Basic frame: after reset, frame_sync+in_valid, then stream bits 1,0,0,1,1,0,1,1 for slots 0..7 -> one cycle after the slot-7 edge out0..out7=1,0,0,1,1,0,1,1, single frame_valid pulse, locked=1.
- Gapped input: same frame with in_valid low on alternating cycles -> identical outputs; frame_valid only after the 8th valid bit; outputs unchanged during gaps.
- Early sync: frame_sync asserted at slot 4 -> sync_err pulse, no frame_valid, previous outputs held, next 8 bits form a correct frame.
- Lost sync: two consecutive frames with frame_sync never asserted -> sync_err on each slot-0 bit, locked falls after the 2nd miss, outputs hold until a new frame_sync arrives.
- Reset mid-frame: assert reset at slot 3 -> outputs immediately 8'h00, slot=0, locked=0, no frame_valid.
- Loopback: drive the 8x1 mux with select counting 0..7 and frame_sync at select=0, inputs 8'b1101_1001 -> out7..out0 = 1101_1001 every frame.
- Parity (TDM_PARITY_EN builds only): wrong parity bit at slot 8 -> parity_err pulse, outputs held.
